// File: rtl/con_bridge_pkg.sv
// Shared types and byte codes for the console/debug memory bridge.
package con_bridge_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StAddrHi,
      StAddrLo,
      StWdata,
      StWrite,
      StAck,
      StRlen,
      StRwait,
      StRsend,
      StNak
   } state_e;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RSP_ACK   = 8'h4B;
   localparam logic [7:0] RSP_NAK   = 8'h3F;

   function automatic logic is_cmd(input logic [7:0] b);
      return (b == CMD_WRITE) || (b == CMD_READ);
   endfunction

endpackage

// File: rtl/con_bridge_txbuf.sv
// Response byte buffer: holds one word (or a single byte in the top lane) and
// shifts it out MSB first over a valid/ready handshake.
module con_bridge_txbuf (
   input  logic        CLK,
   input  logic        nrst,
   input  logic        load_i,
   input  logic        four_i,
   input  logic [31:0] word_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [7:0]  data_o,
   output logic        last_o
);

   logic [31:0] sr_q;
   logic [2:0]  cnt_q;

   // The controller only loads while the buffer is drained.
   always_ff @(posedge CLK) begin
      if (!nrst) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (load_i) begin
         sr_q  <= word_i;
         cnt_q <= four_i ? 3'd4 : 3'd1;
      end else if (valid_o && ready_i) begin
         sr_q  <= {sr_q[23:0], 8'h00};
         cnt_q <= cnt_q - 3'd1;
      end
   end

   assign valid_o = (cnt_q != 3'd0);
   assign data_o  = sr_q[31:24];
   assign last_o  = (cnt_q == 3'd1);

endmodule

// File: rtl/con_bridge.sv
// Host byte-stream to BLOCKMEM console port bridge: word writes, burst reads,
// ACK/NAK responses, and an inter-byte timeout for abandoned commands.
module con_bridge
   import con_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned READ_LAT = 1,
   parameter int unsigned TIMEOUT  = 65535
) (
   input  logic              CLK,
   input  logic              nrst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [7:0]        out_data,
   input  logic              out_ready,
   output logic [3:0]        con_write,
   output logic [ADDR_W-1:0] con_addr,
   output logic [31:0]       con_in,
   input  logic [31:0]       con_out,
   output logic              busy
);

   localparam logic [1:0]  LatW = 2'(READ_LAT);
   localparam logic [15:0] TmoW = 16'(TIMEOUT);

   state_e            state_q;
   logic [7:0]        hi_q;
   logic [7:0]        rem_q;
   logic [23:0]       wbuf_q;
   logic [1:0]        bcnt_q;
   logic [1:0]        wait_q;
   logic              is_wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       tmo_q;
   logic [3:0]        con_write_q;
   logic [ADDR_W-1:0] con_addr_q;
   logic [31:0]       con_in_q;

   logic        in_acc, rx_wait, tmo_hit;
   logic        tx_load, tx_four, tx_acc, tx_last;
   logic [31:0] tx_word;

   assign in_ready = (state_q == StIdle) || (state_q == StAddrHi) || (state_q == StAddrLo) ||
                     (state_q == StWdata) || (state_q == StRlen);
   assign in_acc   = in_valid && in_ready;
   assign rx_wait  = in_ready && (state_q != StIdle);
   assign tmo_hit  = rx_wait && (tmo_q == TmoW);
   assign tx_acc   = out_valid && out_ready;
   assign busy     = (state_q != StIdle);

   assign con_write = con_write_q;
   assign con_addr  = con_addr_q;
   assign con_in    = con_in_q;

   always_comb begin
      tx_load = 1'b0;
      tx_four = 1'b0;
      tx_word = '0;
      if (state_q == StIdle && in_acc && !is_cmd(in_data)) begin
         tx_load = 1'b1;
         tx_word = {RSP_NAK, 24'h0};
      end else if (state_q == StWrite) begin
         tx_load = 1'b1;
         tx_word = {RSP_ACK, 24'h0};
      end else if (state_q == StRwait && wait_q == LatW) begin
         tx_load = 1'b1;
         tx_four = 1'b1;
         tx_word = con_out;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nrst) begin
         state_q     <= StIdle;
         hi_q        <= '0;
         rem_q       <= '0;
         wbuf_q      <= '0;
         bcnt_q      <= '0;
         wait_q      <= '0;
         is_wr_q     <= 1'b0;
         addr_q      <= '0;
         tmo_q       <= '0;
         con_write_q <= '0;
         con_addr_q  <= '0;
         con_in_q    <= '0;
      end else begin
         con_write_q <= 4'h0;
         tmo_q <= (in_acc || !rx_wait || tmo_hit) ? 16'd0 : tmo_q + 16'd1;
         unique case (state_q)
            StIdle: begin
               if (in_acc) begin
                  is_wr_q <= (in_data == CMD_WRITE);
                  state_q <= is_cmd(in_data) ? StAddrHi : StNak;
               end
            end
            StAddrHi: begin
               if (in_acc) begin
                  hi_q    <= in_data;
                  state_q <= StAddrLo;
               end else if (tmo_hit) begin
                  state_q <= StIdle;
               end
            end
            StAddrLo: begin
               if (in_acc) begin
                  addr_q  <= ADDR_W'({hi_q, in_data});
                  bcnt_q  <= 2'd0;
                  state_q <= is_wr_q ? StWdata : StRlen;
               end else if (tmo_hit) begin
                  state_q <= StIdle;
               end
            end
            StWdata: begin
               if (in_acc) begin
                  wbuf_q <= {wbuf_q[15:0], in_data};
                  bcnt_q <= bcnt_q + 2'd1;
                  if (bcnt_q == 2'd3) begin
                     con_write_q <= 4'hF;
                     con_addr_q  <= addr_q;
                     con_in_q    <= {wbuf_q, in_data};
                     state_q     <= StWrite;
                  end
               end else if (tmo_hit) begin
                  state_q <= StIdle;
               end
            end
            StWrite: state_q <= StAck;
            StAck, StNak: begin
               if (tx_acc) state_q <= StIdle;
            end
            StRlen: begin
               if (in_acc) begin
                  rem_q      <= in_data;
                  wait_q     <= 2'd0;
                  con_addr_q <= addr_q;
                  state_q    <= StRwait;
               end else if (tmo_hit) begin
                  state_q <= StIdle;
               end
            end
            // Capture happens in the cycle where wait_q reaches the read latency.
            StRwait: begin
               if (wait_q == LatW) state_q <= StRsend;
               else                wait_q  <= wait_q + 2'd1;
            end
            StRsend: begin
               if (tx_acc && tx_last) begin
                  if (rem_q == 8'd0) begin
                     state_q <= StIdle;
                  end else begin
                     rem_q      <= rem_q - 8'd1;
                     addr_q     <= addr_q + ADDR_W'(1);
                     con_addr_q <= addr_q + ADDR_W'(1);
                     wait_q     <= 2'd0;
                     state_q    <= StRwait;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   con_bridge_txbuf u_txbuf (
      .CLK     (CLK),
      .nrst    (nrst),
      .load_i  (tx_load),
      .four_i  (tx_four),
      .word_i  (tx_word),
      .ready_i (out_ready),
      .valid_o (out_valid),
      .data_o  (out_data),
      .last_o  (tx_last)
   );

endmodule

// File: tb/tb_con_bridge.sv
// Bench for con_bridge: fixed command table, hand-written corner sequences and
// random commands checked against a word-level memory/response model.
module tb_con_bridge;

   localparam int unsigned ADDR_W   = 10;
   localparam int unsigned READ_LAT = 2;
   localparam int unsigned TIMEOUT  = 40;
   localparam int          DEPTH    = 1 << ADDR_W;

   logic              CLK = 1'b0;
   logic              nrst;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              out_valid;
   logic [7:0]        out_data;
   logic              out_ready;
   logic [3:0]        con_write;
   logic [ADDR_W-1:0] con_addr;
   logic [31:0]       con_in;
   logic [31:0]       con_out;
   logic              busy;

   con_bridge #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .TIMEOUT(TIMEOUT)) dut (
      .CLK       (CLK),
      .nrst      (nrst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .con_write (con_write),
      .con_addr  (con_addr),
      .con_in    (con_in),
      .con_out   (con_out),
      .busy      (busy)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] init_word(input int i);
      return 32'hC0DE0000 ^ (i * 32'h00010103);
   endfunction

   // BLOCKMEM stand-in with a READ_LAT-deep registered read path.
   logic [31:0] mem [DEPTH];
   logic [31:0] rd_pipe [READ_LAT];
   logic        mem_init = 1'b0;
   always @(posedge CLK) begin
      if (!mem_init) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
         mem_init <= 1'b1;
      end else if (con_write == 4'hF) begin
         mem[con_addr] <= con_in;
      end
      rd_pipe[0] <= mem[con_addr];
      for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign con_out = rd_pipe[READ_LAT-1];

   int rdy_mode = 0;
   int cyc = 0;
   always @(posedge CLK) begin
      #1;
      cyc++;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = (cyc % 3 == 0);
      endcase
   end

   typedef struct {
      logic [3:0]        we;
      logic [ADDR_W-1:0] a;
      logic [31:0]       d;
   } wr_t;

   logic [7:0]        rx_q[$];
   wr_t               wr_q[$];
   logic [ADDR_W-1:0] addr_log[$];
   logic [ADDR_W-1:0] last_addr = '0;
   int                stab_err = 0;
   logic              stall_q = 1'b0;
   logic [7:0]        stall_data = 8'h00;

   always @(negedge CLK) begin
      wr_t w;
      if (!nrst) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q && (!out_valid || out_data != stall_data)) stab_err++;
         stall_q    = out_valid && !out_ready;
         stall_data = out_data;
         if (out_valid && out_ready) rx_q.push_back(out_data);
         if (con_write != 4'h0) begin
            w.we = con_write;
            w.a  = con_addr;
            w.d  = con_in;
            wr_q.push_back(w);
         end
      end
      if (con_addr != last_addr) addr_log.push_back(con_addr);
      last_addr = con_addr;
   end

   int checks = 0;
   int fails  = 0;
   logic [31:0] ref_mem [DEPTH];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      @(negedge CLK);
      while (!in_ready && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      chk("send_accept", 32'(in_ready), 32'd1);
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
   endtask

   // Word-level reference: memory array plus the response each command earns.
   task automatic model_cmd(input logic [7:0] cmd[$], output logic [7:0] rsp[$], output bit wr,
                            output logic [ADDR_W-1:0] a, output logic [31:0] d);
      int base;
      logic [31:0] w;
      rsp.delete();
      wr = 1'b0;
      a  = '0;
      d  = '0;
      if (cmd[0] == 8'h57) begin
         base = {cmd[1], cmd[2]};
         a = ADDR_W'(base % DEPTH);
         d = {cmd[3], cmd[4], cmd[5], cmd[6]};
         ref_mem[base % DEPTH] = d;
         wr = 1'b1;
         rsp.push_back(8'h4B);
      end else if (cmd[0] == 8'h52) begin
         base = {cmd[1], cmd[2]};
         for (int k = 0; k <= int'(cmd[3]); k++) begin
            w = ref_mem[(base + k) % DEPTH];
            for (int j = 3; j >= 0; j--) rsp.push_back(w[8*j +: 8]);
         end
      end else begin
         rsp.push_back(8'h3F);
      end
   endtask

   task automatic run_cmd(input string name, input logic [7:0] cmd[$], input logic [7:0] exp[$],
                          input bit exp_wr, input logic [ADDR_W-1:0] exp_a,
                          input logic [31:0] exp_d, input int gap_max);
      int rx0 = rx_q.size();
      int wr0 = wr_q.size();
      int n = 0;
      int g;
      foreach (cmd[i]) begin
         g = $urandom_range(0, gap_max);
         if (g != 0) begin
            repeat (g) @(posedge CLK);
            #1;
         end
         send_byte(cmd[i]);
      end
      while ((rx_q.size() - rx0 < exp.size() || busy) && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      repeat (2) @(posedge CLK);
      #1;
      chk({name, "_done"}, 32'(n < 3000), 32'd1);
      chk({name, "_nrsp"}, 32'(rx_q.size() - rx0), 32'(exp.size()));
      foreach (exp[i])
         if (rx0 + i < rx_q.size()) chk($sformatf("%s_b%0d", name, i), 32'(rx_q[rx0+i]), 32'(exp[i]));
      chk({name, "_nwr"}, 32'(wr_q.size() - wr0), exp_wr ? 32'd1 : 32'd0);
      if (exp_wr && wr_q.size() > wr0) begin
         chk({name, "_we"}, 32'(wr_q[wr0].we), 32'hF);
         chk({name, "_wa"}, 32'(wr_q[wr0].a), 32'(exp_a));
         chk({name, "_wd"}, wr_q[wr0].d, exp_d);
      end
   endtask

   typedef struct {
      int                nb;
      logic [7:0]        b [7];
      int                nr;
      logic [7:0]        r [8];
      bit                wr;
      logic [ADDR_W-1:0] a;
      logic [31:0]       d;
   } vec_t;

   vec_t tbl [8];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]        cq[$];
      logic [7:0]        eq[$];
      bit                ewr;
      logic [ADDR_W-1:0] ea;
      logic [31:0]       ed;
      int                al0, wr0, rx0, kind;
      logic [7:0]        op;

      tbl[0] = '{7, '{8'h57, 8'h00, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1,
                 '{8'h4B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 10'h005, 32'hDEADBEEF};
      tbl[1] = '{4, '{8'h52, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00}, 4,
                 '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 10'h000, 32'h0};
      tbl[2] = '{7, '{8'h57, 8'h03, 8'hFF, 8'h11, 8'h11, 8'h11, 8'h11}, 1,
                 '{8'h4B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 10'h3FF, 32'h11111111};
      tbl[3] = '{7, '{8'h57, 8'h00, 8'h00, 8'h22, 8'h22, 8'h22, 8'h22}, 1,
                 '{8'h4B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 10'h000, 32'h22222222};
      tbl[4] = '{4, '{8'h52, 8'h03, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00}, 8,
                 '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22}, 1'b0, 10'h000, 32'h0};
      tbl[5] = '{1, '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1,
                 '{8'h3F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 10'h000, 32'h0};
      // Upper address bits beyond ADDR_W are dropped: 0xFC07 lands on word 7.
      tbl[6] = '{7, '{8'h57, 8'hFC, 8'h07, 8'h01, 8'h02, 8'h03, 8'h04}, 1,
                 '{8'h4B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 10'h007, 32'h01020304};
      tbl[7] = '{4, '{8'h52, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00}, 4,
                 '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 10'h000, 32'h0};

      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

      nrst     = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(posedge CLK);
      #1;
      nrst = 1'b1;
      @(negedge CLK);
      chk("rst_con_write", 32'(con_write), 32'h0);
      chk("rst_con_addr", 32'(con_addr), 32'h0);
      chk("rst_con_in", con_in, 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h1);
      @(posedge CLK);
      #1;

      for (int i = 0; i < 8; i++) begin
         cq.delete();
         eq.delete();
         for (int j = 0; j < tbl[i].nb; j++) cq.push_back(tbl[i].b[j]);
         for (int j = 0; j < tbl[i].nr; j++) eq.push_back(tbl[i].r[j]);
         al0 = addr_log.size();
         run_cmd($sformatf("vec%0d", i), cq, eq, tbl[i].wr, tbl[i].a, tbl[i].d, 0);
         if (tbl[i].wr) ref_mem[tbl[i].a] = tbl[i].d;
         if (i == 4) begin
            chk("burst_naddr", 32'(addr_log.size() - al0), 32'd2);
            if (addr_log.size() >= al0 + 2) begin
               chk("burst_addr0", 32'(addr_log[al0]), 32'h3FF);
               chk("burst_addr1", 32'(addr_log[al0+1]), 32'h000);
            end
         end
      end

      // Four-word read under 1-of-3 backpressure.
      rdy_mode = 2;
      cq = {8'h52, 8'h00, 8'h05, 8'h03};
      model_cmd(cq, eq, ewr, ea, ed);
      run_cmd("bp_read", cq, eq, ewr, ea, ed, 0);

      rdy_mode = 1;
      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 9);
         cq.delete();
         if (kind < 4) begin
            cq.push_back(8'h57);
            cq.push_back(8'($urandom_range(0, 255)));
            cq.push_back(8'($urandom_range(0, 255)));
            for (int j = 0; j < 4; j++) cq.push_back(8'($urandom_range(0, 255)));
         end else if (kind < 8) begin
            cq.push_back(8'h52);
            cq.push_back(8'($urandom_range(0, 255)));
            cq.push_back((kind == 7) ? 8'hFE : 8'($urandom_range(0, 255)));
            cq.push_back(8'($urandom_range(0, 3)));
         end else begin
            op = 8'($urandom_range(0, 255));
            while (op == 8'h57 || op == 8'h52) op = 8'($urandom_range(0, 255));
            cq.push_back(op);
         end
         model_cmd(cq, eq, ewr, ea, ed);
         run_cmd($sformatf("rnd%0d", t), cq, eq, ewr, ea, ed, 3);
      end

      // Abandoned write: must abort silently after the idle limit.
      rdy_mode = 0;
      wr0 = wr_q.size();
      rx0 = rx_q.size();
      send_byte(8'h57);
      send_byte(8'h00);
      send_byte(8'h07);
      repeat (TIMEOUT + 1) @(negedge CLK);
      chk("tmo_busy_before", 32'(busy), 32'd1);
      repeat (2) @(negedge CLK);
      chk("tmo_busy_after", 32'(busy), 32'd0);
      @(posedge CLK);
      #1;
      chk("tmo_nwr", 32'(wr_q.size() - wr0), 32'd0);
      chk("tmo_nrsp", 32'(rx_q.size() - rx0), 32'd0);
      cq = {8'h52, 8'h00, 8'h07, 8'h00};
      model_cmd(cq, eq, ewr, ea, ed);
      run_cmd("tmo_read", cq, eq, ewr, ea, ed, 0);

      // Reset in the middle of the data bytes.
      wr0 = wr_q.size();
      send_byte(8'h57);
      send_byte(8'h00);
      send_byte(8'h07);
      send_byte(8'hAA);
      send_byte(8'hBB);
      nrst = 1'b0;
      @(posedge CLK);
      #1;
      nrst = 1'b1;
      @(negedge CLK);
      chk("mrst_con_write", 32'(con_write), 32'h0);
      chk("mrst_con_addr", 32'(con_addr), 32'h0);
      chk("mrst_con_in", con_in, 32'h0);
      chk("mrst_out_valid", 32'(out_valid), 32'h0);
      chk("mrst_out_data", 32'(out_data), 32'h0);
      chk("mrst_busy", 32'(busy), 32'h0);
      repeat (5) @(posedge CLK);
      #1;
      chk("mrst_nwr", 32'(wr_q.size() - wr0), 32'd0);
      cq = {8'h52, 8'h00, 8'h07, 8'h00};
      model_cmd(cq, eq, ewr, ea, ed);
      run_cmd("mrst_read", cq, eq, ewr, ea, ed, 0);

      chk("out_stable", 32'(stab_err), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
